mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port unified instruction/data memory between two requesters. Port 0 is the CPU core, covering both fetch and load/store. Port 1 is a loader/debug master that writes programs and inspects memory. The block sits between the requesters and the `mem` instance, and it owns the memory address, write-enable and write-data mux. Read data returns one cycle after grant, matching the memory's registered read.

## Interface
- `ADDR_W`, default 6: memory word-address width.
- `DATA_W`, default 32: data width.
- `BURST_MAX`, default 4: maximum consecutive transfers per ownership. Range 1..15. Used only with the configuration macro below.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `p0_req` / `p1_req`  in  1  transfer request.
- `p0_we` / `p1_we`  in  1  1 = write, 0 = read.
- `p0_addr` / `p1_addr`  in  ADDR_W  word address.
- `p0_wdata` / `p1_wdata`  in  DATA_W  write data.
- `p0_gnt` / `p1_gnt`  out  1  transfer accepted this cycle. Combinational.
- `p0_rvalid` / `p1_rvalid`  out  1  read data valid. Registered.
- `p0_rdata` / `p1_rdata`  out  DATA_W  read data. Meaningful only while the matching `rvalid` is 1.
- `mem_addr`  out  ADDR_W  to memory.
- `mem_we`  out  1  to memory.
- `mem_wdata`  out  DATA_W  to memory.
- `mem_rdata`  in  DATA_W  from memory. Valid the cycle after its address was presented.

## Operation
- A transfer occurs in a cycle where `pX_req && pX_gnt`. At most one grant per cycle.
- `mem_addr`, `mem_we` and `mem_wdata` are muxed from the granted port.
  - With no grant: `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Requester protocol: hold `req`, `we`, `addr` and `wdata` stable until `gnt` is seen. Dropping `req` before grant is legal and cancels the request.
- Arbitration, base round-robin:
  - Single requester always wins.
  - If both request, the winner is the port not granted on the most recent transfer.
  - `last_gnt` updates on every transfer.
- Reads: `pX_rvalid` is set for exactly one cycle, the cycle after a granted read by port X.
  - `pX_rdata` = `mem_rdata`, passed through.
  - Writes produce no `rvalid`.
  - At most one `rvalid` is high per cycle.
- Write then read of the same address on consecutive cycles, from either port, returns the new data.

## Timing
- Reset values: `last_gnt` = P1 (so P0 wins the first tie); owner = NONE; `burst_cnt` = 0; both `rvalid` = 0.
- While `rst` = 1: both `gnt` forced to 0 and `mem_we` = 0, regardless of `req`.
- A read in flight when `rst` rises has its `rvalid` suppressed.
- Grant latency: 0 cycles, same cycle as `req` when the port wins.
- Read latency: `rvalid` 1 cycle after grant.
- Throughput: one transfer per cycle. Switching between ports costs no bubble.
- Combinational paths:
  - `req` to `gnt` to `mem_*`.
  - `mem_rdata` to `pX_rdata`, nothing else.
  - `rvalid` comes only from flops.

## Configuration
- `MEM_ARB_BURST_EN` undefined: pure per-cycle round-robin as above. `BURST_MAX` is ignored, and the owner and counter logic is absent.
- `MEM_ARB_BURST_EN` defined: burst locking.
  - Registers `owner` (NONE/P0/P1) and `burst_cnt` (4 bits).
  - Owner keeps the grant while its `req` = 1 and `burst_cnt < BURST_MAX`. `burst_cnt` increments per owner transfer.
  - At `burst_cnt == BURST_MAX`:
    - Other port requesting: ownership passes to it, `burst_cnt` = 1.
    - Otherwise: owner continues, `burst_cnt` restarts at 1.
  - Owner drops `req`: owner becomes the new winner under round-robin rules, or NONE if there is no request. `burst_cnt` = 1 on new ownership, 0 on NONE.
  - `BURST_MAX` = 1 behaves identically to the macro-undefined build.

## Test plan
- Reset: `rst` = 1 for 2 cycles with both `req` = 1, `we` = 1 → both `gnt` = 0, `mem_we` = 0, both `rvalid` = 0. First cycle after release → `p0_gnt` = 1.
- Single read: `mem[5]` = 0x00001234, P0 reads addr 5 at cycle N → `p0_gnt` at N, `p0_rvalid` = 1 with `p0_rdata` = 0x00001234 at N+1, `p1_rvalid` stays 0.
- Write/read forwarding: P1 writes 0xDEADBEEF to addr 7 at N, P0 reads addr 7 at N+1 → `p0_rdata` = 0xDEADBEEF at N+2.
- Continuous contention, both `req` held for 8 cycles:
  - Macro undefined → grant sequence P0,P1,P0,P1,…
  - Macro defined, `BURST_MAX` = 4 → P0×4 then P1×4.
- Burst release (macro defined): P0 owns with `burst_cnt` = 2, drops `req` while P1 requests → `p1_gnt` in the next cycle, no idle cycle.
- Reset mid-read: P1 read granted at N, `rst` = 1 at N+1 → `p1_rvalid` = 0 at N+1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port unified memory: CPU on port 0, loader/debug on port 1.
// Round-robin per transfer by default; define MEM_ARB_BURST_EN to lock ownership for up to BURST_MAX.
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (BURST_MAX < 1 || BURST_MAX > 15) begin : gen_bad_burst_max
    $error("mem_arbiter: BURST_MAX must be in 1..15");
  end

  logic last_gnt_q;  // 1: port 1 had the most recent transfer
  logic p0_rvalid_q, p1_rvalid_q;
  logic rr0, rr1, sel0, sel1;

  always_comb begin
    rr0 = p0_req && (!p1_req || last_gnt_q);
    rr1 = p1_req && (!p0_req || !last_gnt_q);
  end

`ifdef MEM_ARB_BURST_EN
  typedef enum logic [1:0] {OwnNone, OwnP0, OwnP1} owner_e;

  localparam logic [3:0] BurstMax = 4'(BURST_MAX);

  owner_e     owner_q, owner_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;

  // A saturated owner only yields if the other port is waiting; round-robin then picks the other.
  always_comb begin
    sel0 = rr0;
    sel1 = rr1;
    unique case (owner_q)
      OwnP0: if (p0_req && (burst_cnt_q < BurstMax || !p1_req)) begin
        sel0 = 1'b1;
        sel1 = 1'b0;
      end
      OwnP1: if (p1_req && (burst_cnt_q < BurstMax || !p0_req)) begin
        sel0 = 1'b0;
        sel1 = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_d     = OwnNone;
    burst_cnt_d = 4'd0;
    if (p0_gnt) begin
      owner_d     = OwnP0;
      burst_cnt_d = (owner_q == OwnP0 && burst_cnt_q < BurstMax) ? burst_cnt_q + 4'd1 : 4'd1;
    end else if (p1_gnt) begin
      owner_d     = OwnP1;
      burst_cnt_d = (owner_q == OwnP1 && burst_cnt_q < BurstMax) ? burst_cnt_q + 4'd1 : 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OwnNone;
      burst_cnt_q <= 4'd0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  always_comb begin
    sel0 = rr0;
    sel1 = rr1;
  end
`endif

  always_comb begin
    p0_gnt = sel0 && !rst;
    p1_gnt = sel1 && !rst;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (p0_gnt) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (p1_gnt) begin
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q  <= 1'b1;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      if (p0_gnt) begin
        last_gnt_q <= 1'b0;
      end else if (p1_gnt) begin
        last_gnt_q <= 1'b1;
      end
      p0_rvalid_q <= p0_gnt && !p0_we;
      p1_rvalid_q <= p1_gnt && !p1_we;
    end
  end

  // Reset kills a read whose data would land in the reset cycle.
  always_comb begin
    p0_rvalid = p0_rvalid_q && !rst;
    p1_rvalid = p1_rvalid_q && !rst;
    p0_rdata  = mem_rdata;
    p1_rdata  = mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read memory model behind the arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [5:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [5:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [64];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p0_gnt    (p0_gnt),
    .p1_gnt    (p1_gnt),
    .p0_rvalid (p0_rvalid),
    .p1_rvalid (p1_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_rdata  (p1_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic        p0_req, p0_we;
    logic [5:0]  p0_addr;
    logic [31:0] p0_wdata;
    logic        p1_req, p1_we;
    logic [5:0]  p1_addr;
    logic [31:0] p1_wdata;
    logic        e_g0, e_g1, e_mwe;
    logic [5:0]  e_maddr;
    logic [31:0] e_mwdata;
    logic        e_rv0, e_rv1;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [5:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [5:0] a1,
                       input logic [31:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  // One cycle: inputs change just after the edge, outputs are sampled at the falling edge.
  task automatic step(input logic r0, input logic w0, input logic [5:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [5:0] a1,
                      input logic [31:0] d1);
    @(posedge clk);
    #1 drive(r0, w0, a0, d0, r1, w1, a1, d1);
    @(negedge clk);
  endtask

  initial begin
    logic exp_g0, prev_g0;
    string tag;

    vecs[0]  = '{1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b1, 6'd5, 32'h00001234,
                 1'b0, 1'b1, 1'b1, 6'd5, 32'h00001234, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 6'd5, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0,
                 1'b1, 1'b0, 1'b0, 6'd5, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0,
                 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 32'h00001234};
    vecs[3]  = '{1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b1, 6'd7, 32'hDEADBEEF,
                 1'b0, 1'b1, 1'b1, 6'd7, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 6'd7, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0,
                 1'b1, 1'b0, 1'b0, 6'd7, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 6'd5, 32'h0,
                 1'b0, 1'b1, 1'b0, 6'd5, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 1'b1, 6'd5, 32'hCAFEF00D, 1'b0, 1'b0, 6'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 6'd5, 32'hCAFEF00D, 1'b0, 1'b1, 32'h00001234};
    vecs[7]  = '{1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 6'd5, 32'h0,
                 1'b0, 1'b1, 1'b0, 6'd5, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 6'd7, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0,
                 1'b1, 1'b0, 1'b0, 6'd7, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[9]  = '{1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0,
                 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 6'd7, 32'h0,
                 1'b0, 1'b1, 1'b0, 6'd7, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0,
                 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};

    // Reset held two cycles with both ports requesting writes.
    rst = 1'b1;
    drive(1'b1, 1'b1, 6'd1, 32'h11111111, 1'b1, 1'b1, 6'd2, 32'h22222222);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rst%0d.p0_gnt", c), {31'b0, p0_gnt}, 32'd0);
      chk($sformatf("rst%0d.p1_gnt", c), {31'b0, p1_gnt}, 32'd0);
      chk($sformatf("rst%0d.mem_we", c), {31'b0, mem_we}, 32'd0);
      chk($sformatf("rst%0d.p0_rvalid", c), {31'b0, p0_rvalid}, 32'd0);
      chk($sformatf("rst%0d.p1_rvalid", c), {31'b0, p1_rvalid}, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("release.p0_gnt", {31'b0, p0_gnt}, 32'd1);
    chk("release.p1_gnt", {31'b0, p1_gnt}, 32'd0);
    chk("release.mem_addr", {26'b0, mem_addr}, 32'd1);
    chk("release.mem_we", {31'b0, mem_we}, 32'd1);
    step(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    chk("release.p0_rvalid", {31'b0, p0_rvalid}, 32'd0);

    // Single-requester traffic: writes, reads, forwarding, rvalid routing.
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].p0_req, vecs[i].p0_we, vecs[i].p0_addr, vecs[i].p0_wdata,
           vecs[i].p1_req, vecs[i].p1_we, vecs[i].p1_addr, vecs[i].p1_wdata);
      chk($sformatf("v%0d.p0_gnt", i), {31'b0, p0_gnt}, {31'b0, vecs[i].e_g0});
      chk($sformatf("v%0d.p1_gnt", i), {31'b0, p1_gnt}, {31'b0, vecs[i].e_g1});
      chk($sformatf("v%0d.mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_mwe});
      chk($sformatf("v%0d.mem_addr", i), {26'b0, mem_addr}, {26'b0, vecs[i].e_maddr});
      chk($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
      chk($sformatf("v%0d.p0_rvalid", i), {31'b0, p0_rvalid}, {31'b0, vecs[i].e_rv0});
      chk($sformatf("v%0d.p1_rvalid", i), {31'b0, p1_rvalid}, {31'b0, vecs[i].e_rv1});
      if (vecs[i].e_rv0) chk($sformatf("v%0d.p0_rdata", i), p0_rdata, vecs[i].e_rdata);
      if (vecs[i].e_rv1) chk($sformatf("v%0d.p1_rdata", i), p1_rdata, vecs[i].e_rdata);
    end

    // Continuous contention: P0 reads addr 5, P1 reads addr 7; P1 had the last transfer.
    prev_g0 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) step(1'b1, 1'b0, 6'd5, 32'h0, 1'b1, 1'b0, 6'd7, 32'h0);
      else       step(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
`ifdef MEM_ARB_BURST_EN
      exp_g0 = (k < 4);
`else
      exp_g0 = (k % 2 == 0);
`endif
      tag = $sformatf("cont%0d", k);
      if (k < 8) begin
        chk({tag, ".p0_gnt"}, {31'b0, p0_gnt}, {31'b0, exp_g0});
        chk({tag, ".p1_gnt"}, {31'b0, p1_gnt}, {31'b0, !exp_g0});
        chk({tag, ".mem_addr"}, {26'b0, mem_addr}, exp_g0 ? 32'd5 : 32'd7);
      end
      if (k > 0) begin
        chk({tag, ".p0_rvalid"}, {31'b0, p0_rvalid}, {31'b0, prev_g0});
        chk({tag, ".p1_rvalid"}, {31'b0, p1_rvalid}, {31'b0, !prev_g0});
        chk({tag, ".rdata"}, prev_g0 ? p0_rdata : p1_rdata,
            prev_g0 ? 32'hCAFEF00D : 32'hDEADBEEF);
      end
      prev_g0 = exp_g0;
    end

    // P0 alone for 6 transfers (continues past a full burst), then hands over with no bubble.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 6'd5, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
      chk($sformatf("solo%0d.p0_gnt", k), {31'b0, p0_gnt}, 32'd1);
    end
    step(1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 6'd7, 32'h0);
    chk("handover.p1_gnt", {31'b0, p1_gnt}, 32'd1);
    chk("handover.p0_gnt", {31'b0, p0_gnt}, 32'd0);
    chk("handover.p0_rvalid", {31'b0, p0_rvalid}, 32'd1);

    // Reset arriving while P1's read is in flight.
    step(1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 6'd7, 32'h0);
    chk("midrst.p1_gnt", {31'b0, p1_gnt}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b1, 1'b1, 6'd9, 32'h99, 1'b0, 1'b0, 6'd0, 32'h0);
    @(negedge clk);
    chk("midrst.p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
    chk("midrst.p0_gnt", {31'b0, p0_gnt}, 32'd0);
    chk("midrst.mem_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 1'b0, 6'd5, 32'h0, 1'b1, 1'b0, 6'd7, 32'h0);
    @(negedge clk);
    chk("postrst.p0_gnt", {31'b0, p0_gnt}, 32'd1);
    chk("postrst.p1_gnt", {31'b0, p1_gnt}, 32'd0);
    chk("postrst.p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
    step(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    chk("postrst.p0_rvalid", {31'b0, p0_rvalid}, 32'd1);
    chk("postrst.p0_rdata", p0_rdata, 32'hCAFEF00D);
    chk("postrst.p1_rvalid2", {31'b0, p1_rvalid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
